// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and its stall/flush controller.
// The controller side is master; the datapath side is slave.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] if_id_rs1;
    logic [REG_W-1:0] if_id_rs2;
    logic [REG_W-1:0] id_ex_rd;
    logic             id_ex_memread;
    logic             branch_taken;
    logic             ex_mem_memacc;
    logic             mem_ready;
    logic             err_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_flush;
    logic             mem_req;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    modport master (
        input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread,
        input  branch_taken, ex_mem_memacc, mem_ready, err_clr,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, mem_wb_flush, mem_req, mem_error, stall_count
    );

    modport slave (
        output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_memread,
        output branch_taken, ex_mem_memacc, mem_ready, err_clr,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, mem_wb_flush, mem_req, mem_error, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable/flush control: load-use stall, branch flush,
// data-memory hold with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.master hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

    localparam int WC_W = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [WC_W-1:0] wcnt_q, wcnt_d;
    logic            err_q, err_set;
    logic [CNT_W-1:0] cnt_q;
    logic            load_use;
    logic            pc_en, if_id_en, if_id_flush, id_ex_en;
    logic            id_ex_flush, ex_mem_en, mem_wb_flush, mem_req;

    assign load_use = hz.id_ex_memread && (hz.id_ex_rd != '0) &&
                      ((hz.id_ex_rd == hz.if_id_rs1) ||
                       (hz.id_ex_rd == hz.if_id_rs2));

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        err_set      = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        mem_req      = 1'b0;
        unique case (state_q)
            RUN: begin
                mem_req = hz.ex_mem_memacc;
                if (hz.ex_mem_memacc && !hz.mem_ready) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                    state_d      = MEM_WAIT;
                    wcnt_d       = WC_W'(1);
                end else if (hz.branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                if (hz.mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                    if (wcnt_q == WC_LAST) begin
                        state_d = MEM_ERR;
                        wcnt_d  = '0;
                        err_set = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            MEM_ERR: begin
                mem_wb_flush = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
        // Reset forces a free-running pipeline and drops any request at once.
        if (!reset) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_en     = 1'b1;
            id_ex_flush  = 1'b0;
            ex_mem_en    = 1'b1;
            mem_wb_flush = 1'b0;
            mem_req      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (err_set)
                err_q <= 1'b1;
            else if (hz.err_clr)
                err_q <= 1'b0;
            if (!pc_en && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_en    = ex_mem_en;
    assign hz.mem_wb_flush = mem_wb_flush;
    assign hz.mem_req      = mem_req;
    assign hz.mem_error    = err_q;
    assign hz.stall_count  = cnt_q;
endmodule
